// File: rtl/constraint_sweep_if.sv
// constraint_sweep_if: start/done handshake, constraint-select mux port and sweep results.
interface constraint_sweep_if #(
    parameter int NUM_CONS = 32,
    parameter int IDX_W    = 5
);
    logic                start;
    logic                abort;
    logic [NUM_CONS-1:0] cons_mask;
    logic                cons_x;
    logic [IDX_W-1:0]    cons_sel;
    logic                busy;
    logic                done;
    logic                pass;
    logic [IDX_W-1:0]    fail_idx;
    logic [IDX_W:0]      fail_cnt;
    modport master (
        output start, abort, cons_mask, cons_x,
        input  cons_sel, busy, done, pass, fail_idx, fail_cnt
    );
    modport slave (
        input  start, abort, cons_mask, cons_x,
        output cons_sel, busy, done, pass, fail_idx, fail_cnt
    );
endinterface

// File: rtl/constraint_sweep_seq.sv
// constraint_sweep_seq: evaluates one constraint per cycle and reports pass, first failing index and failure count.
// Defining CONS_SWEEP_EARLY_ABORT_EN ends the sweep at the first enabled failure.
module constraint_sweep_seq #(
    parameter int NUM_CONS = 32,
    parameter int IDX_W    = 5
) (
    input logic               clk,
    input logic               rst_n,
    constraint_sweep_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SWEEP, FIN} state_t;
    state_t              state_q, state_d;
    logic [IDX_W-1:0]    sel_q, sel_d;
    logic [NUM_CONS-1:0] mask_q, mask_d;
    logic                pass_q, pass_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W:0]      cnt_q, cnt_d;
    logic                fail;
    logic                last;
    logic                stop;
    assign fail = mask_q[sel_q] && !bus.cons_x;
    assign last = sel_q == IDX_W'(NUM_CONS - 1);
`ifdef CONS_SWEEP_EARLY_ABORT_EN
    assign stop = last || fail;
`else
    assign stop = last;
`endif
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        mask_d  = mask_q;
        pass_d  = pass_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = SWEEP;
                sel_d   = '0;
                mask_d  = bus.cons_mask;
                pass_d  = 1'b0;
                idx_d   = '0;
                cnt_d   = '0;
            end
            SWEEP: if (bus.abort) begin
                state_d = IDLE;
                sel_d   = '0;
            end else begin
                // the first failure is the one seen while the count is still zero
                if (fail) begin
                    cnt_d = cnt_q + 1'b1;
                    idx_d = cnt_q == '0 ? sel_q : idx_q;
                end
                state_d = stop ? FIN : SWEEP;
                sel_d   = stop ? sel_q : sel_q + 1'b1;
                pass_d  = stop && cnt_d == '0;
            end
            FIN: begin
                state_d = IDLE;
                sel_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            mask_q  <= '0;
            pass_q  <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            mask_q  <= mask_d;
            pass_q  <= pass_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end
    assign bus.cons_sel = sel_q;
    assign bus.busy     = state_q != IDLE;
    assign bus.done     = state_q == FIN;
    assign bus.pass     = pass_q;
    assign bus.fail_idx = idx_q;
    assign bus.fail_cnt = cnt_q;
endmodule

// File: tb/tb_constraint_sweep_seq.sv
// tb_constraint_sweep_seq: scoreboard bench; expected sweep results are queued at start and compared on done.
module tb_constraint_sweep_seq;
    typedef struct {
        logic       pass;
        logic [4:0] idx;
        logic [5:0] cnt;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] xpat = '1;
    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          dones = 0;
    logic [31:0] pats[3];
    constraint_sweep_if #(.NUM_CONS(32), .IDX_W(5)) bus ();
    constraint_sweep_seq #(.NUM_CONS(32), .IDX_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    assign bus.cons_x = xpat[bus.cons_sel];
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    function automatic exp_t model(input logic [31:0] m, input logic [31:0] x);
        exp_t e;
        e.cnt = '0;
        e.idx = '0;
        for (int i = 0; i < 32; i++)
            if (m[i] && !x[i]) begin
                if (e.cnt == 0) e.idx = 5'(i);
                e.cnt = e.cnt + 1'b1;
            end
        e.pass = e.cnt == 0;
        return e;
    endfunction
    always @(negedge clk)
        if (rst_n && bus.done) begin
            exp_t e;
            dones++;
            check("sb_nonempty", q.size() != 0, 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("done_pass", bus.pass, e.pass);
                check("done_idx", bus.fail_idx, e.idx);
                check("done_cnt", bus.fail_cnt, e.cnt);
            end
        end
    task automatic run_sweep(input logic [31:0] m, input logic [31:0] x);
        int   n;
        exp_t e;
        e = model(m, x);
        q.push_back(e);
        xpat = x;
        bus.cons_mask = m;
        bus.start = 1'b1;
        step;
        bus.start = 1'b0;
        bus.cons_mask = ~m;
        check("acc_busy", bus.busy, 1);
        check("acc_sel", bus.cons_sel, 0);
        check("acc_cnt", bus.fail_cnt, 0);
        n = 0;
        while (!bus.done && n < 100) begin
            step;
            n++;
        end
        check("latency", n, 32);
        step;
        check("busy_fall", bus.busy, 0);
        check("hold_pass", bus.pass, e.pass);
        check("hold_idx", bus.fail_idx, e.idx);
        check("hold_cnt", bus.fail_cnt, e.cnt);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
    initial begin
        int n;
        int d0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.cons_mask = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_sel", bus.cons_sel, 0);
        check("rst_pass", bus.pass, 0);
        check("rst_cnt", bus.fail_cnt, 0);
        repeat (2) step;
        rst_n = 1'b1;
        step;
        run_sweep('1, '1);
        run_sweep('1, ~((32'h1 << 3) | (32'h1 << 17) | (32'h1 << 31)));
        run_sweep(~(32'h1 << 3), ~((32'h1 << 3) | (32'h1 << 17)));
        run_sweep('0, '0);
        run_sweep('1, ~32'h1);
        run_sweep('1, ~(32'h1 << 31));
        run_sweep('1, '0);
        for (int i = 0; i < 4; i++) run_sweep($urandom, $urandom);
        // start while busy is ignored, then abort drops the sweep with partial results
        xpat = ~((32'h1 << 3) | (32'h1 << 17) | (32'h1 << 20));
        bus.cons_mask = '1;
        bus.start = 1'b1;
        step;
        bus.start = 1'b0;
        repeat (10) step;
        bus.start = 1'b1;
        step;
        bus.start = 1'b0;
        check("busy_start_ignored", bus.cons_sel, 11);
        repeat (9) step;
        check("pre_abort_sel", bus.cons_sel, 20);
        d0 = dones;
        bus.abort = 1'b1;
        step;
        bus.abort = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_sel", bus.cons_sel, 0);
        check("abort_done", bus.done, 0);
        check("abort_pass", bus.pass, 0);
        check("abort_idx", bus.fail_idx, 3);
        check("abort_cnt", bus.fail_cnt, 2);
        check("abort_no_done", dones, d0);
        run_sweep('1, ~(32'h1 << 9));
        // reset in the middle of a sweep
        xpat = ~(32'h1 << 3);
        bus.cons_mask = '1;
        bus.start = 1'b1;
        step;
        bus.start = 1'b0;
        repeat (12) step;
        check("pre_rst_sel", bus.cons_sel, 12);
        d0 = dones;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_sel", bus.cons_sel, 0);
        check("mid_rst_cnt", bus.fail_cnt, 0);
        check("mid_rst_idx", bus.fail_idx, 0);
        check("mid_rst_pass", bus.pass, 0);
        repeat (2) step;
        rst_n = 1'b1;
        repeat (40) step;
        check("mid_rst_idle", bus.busy, 0);
        check("mid_rst_no_done", dones, d0);
        // back-to-back sweeps with start held high
        pats[0] = '1;
        pats[1] = ~(32'h1 << 5);
        pats[2] = ~((32'h1 << 0) | (32'h1 << 31));
        xpat = pats[0];
        bus.cons_mask = '1;
        q.push_back(model('1, pats[0]));
        bus.start = 1'b1;
        step;
        check("b2b_first_acc", bus.busy, 1);
        for (int s = 0; s < 3; s++) begin
            n = 0;
            while (!bus.done && n < 100) begin
                step;
                n++;
            end
            check("b2b_lat", n, 32);
            if (s < 2) begin
                xpat = pats[s+1];
                q.push_back(model('1, pats[s+1]));
                step;
                check("b2b_idle", bus.busy, 0);
                step;
                check("b2b_acc", bus.busy, 1);
                check("b2b_sel", bus.cons_sel, 0);
                check("b2b_clr", bus.fail_cnt, 0);
            end
        end
        bus.start = 1'b0;
        repeat (3) step;
        check("sb_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
